// File: rtl/vectored_mac_ctrl.sv
// Sequencer for the DEPTH x DEPTH vectored MAC array: waits for full input FIFOs,
// clears the accumulators, streams DEPTH words through the MACs and hands off the result.
module vectored_mac_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DEPTH-1:0] a_full,
  input  logic             b_full,
  input  logic [DEPTH-1:0] a_empty,
  input  logic             b_empty,
  output logic [DEPTH-1:0] a_rden,
  output logic             b_rden,
  output logic [DEPTH-1:0] mac_en,
  output logic             mac_clr,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             err
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_CLEAR,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             rden;
  logic             mac_en_p1;
  logic             err_q;

  // rst_n is active-high despite its name
  always_ff @(posedge clk) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_FILL;
      S_FILL:  if ((&a_full) && b_full) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_RUN;
      S_RUN:   if (cnt == CNT_W'(DEPTH - 1)) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_DONE;
      S_DONE:  if (result_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n)                cnt <= '0;
    else if (state == S_CLEAR) cnt <= '0;
    else if (state == S_RUN)   cnt <= cnt + 1'b1;
  end

  // Stage p1: MAC enable lags the FIFO read enable by the FIFO read latency
  always_ff @(posedge clk) begin
    if (rst_n) mac_en_p1 <= 1'b0;
    else       mac_en_p1 <= rden;
  end

  // Underflow is sticky until the next accepted start; the pass is never aborted
  always_ff @(posedge clk) begin
    if (rst_n)
      err_q <= 1'b0;
    else if (state == S_IDLE && start)
      err_q <= 1'b0;
    else if (state == S_RUN && ((|a_empty) || b_empty))
      err_q <= 1'b1;
  end

  always_comb begin
    rden         = (state == S_RUN);
    a_rden       = {DEPTH{rden}};
    b_rden       = rden;
    mac_en       = {DEPTH{mac_en_p1}};
    mac_clr      = (state == S_CLEAR);
    busy         = (state != S_IDLE);
    result_valid = (state == S_DONE);
    err          = err_q;
  end

endmodule

// File: tb/tb_vectored_mac_ctrl.sv
// Bench for vectored_mac_ctrl: directed timing scenarios plus random traffic, all
// checked every cycle against a timeline model and a small FIFO/MAC datapath model.
module tb_vectored_mac_ctrl;

  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, b_full, b_empty, result_ack;
  logic [D-1:0] a_full, a_empty;
  logic [D-1:0] a_rden, mac_en;
  logic         b_rden, mac_clr, busy, result_valid, err;

  vectored_mac_ctrl #(.DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_full(a_full), .b_full(b_full), .a_empty(a_empty), .b_empty(b_empty),
    .a_rden(a_rden), .b_rden(b_rden), .mac_en(mac_en), .mac_clr(mac_clr),
    .busy(busy), .result_valid(result_valid), .result_ack(result_ack), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // FIFO + MAC datapath stand-in: A words are 1, B words are 2, read latency 1
  logic [7:0]  a_dat [D];
  logic [7:0]  b_dat;
  logic [15:0] acc   [D];

  always @(posedge clk) begin
    b_dat <= b_rden ? 8'd2 : 8'd0;
    for (int i = 0; i < D; i++) begin
      a_dat[i] <= a_rden[i] ? 8'd1 : 8'd0;
      if (mac_clr)        acc[i] <= 16'd0;
      else if (mac_en[i]) acc[i] <= acc[i] + 16'(a_dat[i] * b_dat);
    end
  end

  // Timeline model: a pass is idle, waiting for full FIFOs, or scheduled around
  // t_run (first read cycle), from which every output is a fixed offset.
  int mode  = 0;
  int t_run = 0;
  bit err_m = 1'b0;

  int first_clr, first_rd, last_rd, first_me, last_me, first_rv, busy_cnt;

  task automatic mon_reset();
    first_clr = -1; first_rd = -1; last_rd = -1;
    first_me  = -1; last_me  = -1; first_rv = -1; busy_cnt = 0;
  endtask

  task automatic tick();
    int rel;
    bit e_rd, e_me, e_clr, e_busy, e_rv;
    @(negedge clk);
    rel    = cyc - t_run;
    e_busy = (mode != 0);
    e_clr  = (mode == 2) && (rel == -1);
    e_rd   = (mode == 2) && (rel >= 0) && (rel < D);
    e_me   = (mode == 2) && (rel >= 1) && (rel <= D);
    e_rv   = (mode == 2) && (rel >= D + 1);
    check("a_rden", 32'(a_rden), 32'({D{e_rd}}));
    check("b_rden", 32'(b_rden), 32'(e_rd));
    check("mac_en", 32'(mac_en), 32'({D{e_me}}));
    check("mac_clr", 32'(mac_clr), 32'(e_clr));
    check("busy", 32'(busy), 32'(e_busy));
    check("result_valid", 32'(result_valid), 32'(e_rv));
    check("err", 32'(err), 32'(err_m));
    if (mode == 2 && rel == D + 1)
      for (int i = 0; i < D; i++) check($sformatf("cout_row%0d", i), 32'(acc[i]), 32'(2 * D));
    if (mac_clr && first_clr < 0) first_clr = cyc;
    if (b_rden) begin if (first_rd < 0) first_rd = cyc; last_rd = cyc; end
    if (mac_en[0]) begin if (first_me < 0) first_me = cyc; last_me = cyc; end
    if (result_valid && first_rv < 0) first_rv = cyc;
    if (busy) busy_cnt++;
    if (rst_n) begin
      mode = 0; err_m = 1'b0;
    end else begin
      case (mode)
        0: if (start) begin mode = 1; err_m = 1'b0; end
        1: if ((&a_full) && b_full) begin mode = 2; t_run = cyc + 2; end
        default: begin
          if (rel >= 0 && rel < D && ((|a_empty) || b_empty)) err_m = 1'b1;
          if (rel >= D + 1 && result_ack) mode = 0;
        end
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    rst_n = 1'b0; start = 1'b0; result_ack = 1'b0;
    a_full = '1; b_full = 1'b1; a_empty = '0; b_empty = 1'b0;
  endtask

  // Prefilled pass, start at relative 0 and ack at 15; optional spurious start/ack pulses
  task automatic basic_pass(input bit spurious, input string nm);
    int s;
    idle_inputs();
    mon_reset();
    s = cyc;
    for (int k = 0; k < 20; k++) begin
      start      = (k == 0) || (spurious && (k == 5 || k == 13));
      result_ack = (k == 15) || (spurious && k == 1);
      tick();
    end
    idle_inputs();
    check({nm, "_clr_at"}, 32'(first_clr), 32'(s + 2));
    check({nm, "_rd_first"}, 32'(first_rd), 32'(s + 3));
    check({nm, "_rd_last"}, 32'(last_rd), 32'(s + 10));
    check({nm, "_me_first"}, 32'(first_me), 32'(s + 4));
    check({nm, "_me_last"}, 32'(last_me), 32'(s + 11));
    check({nm, "_rv_first"}, 32'(first_rv), 32'(s + 12));
    check({nm, "_busy_cycles"}, 32'(busy_cnt), 32'd15);
  endtask

  initial begin
    int s;
    idle_inputs();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tick(); tick();
    rst_n = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    repeat (3) tick();

    basic_pass(1'b0, "pass1");
    basic_pass(1'b0, "pass2");

    // Fill stalls on B FIFO until relative cycle 30
    idle_inputs(); mon_reset(); s = cyc;
    for (int k = 0; k < 50; k++) begin
      start      = (k == 0);
      b_full     = (k >= 30);
      result_ack = (k == 45);
      tick();
    end
    idle_inputs();
    check("fill_clr_at", 32'(first_clr), 32'(s + 31));
    check("fill_rd_first", 32'(first_rd), 32'(s + 32));

    // Underflow on A row 3 during the fifth read cycle, then a clean pass clears err
    idle_inputs();
    for (int k = 0; k < 20; k++) begin
      start      = (k == 0);
      a_empty    = (k == 7) ? D'(8) : '0;
      result_ack = (k == 15);
      if (k == 14) check("underflow_err_done", 32'(err), 32'd1);
      tick();
    end
    basic_pass(1'b0, "after_err");

    // Reset in the fourth read cycle
    idle_inputs();
    for (int k = 0; k < 10; k++) begin
      start = (k == 0);
      rst_n = (k == 6);
      tick();
    end
    idle_inputs();
    check("midrun_reset_busy", 32'(busy), 32'd0);
    check("midrun_reset_me", 32'(mac_en), 32'd0);
    basic_pass(1'b0, "after_rst");

    basic_pass(1'b1, "spurious");

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      start      = ($urandom_range(0, 7) == 0);
      a_full     = ($urandom_range(0, 3) != 0) ? '1 : D'($urandom);
      b_full     = ($urandom_range(0, 7) != 0);
      a_empty    = ($urandom_range(0, 15) == 0) ? D'(1 << $urandom_range(0, D - 1)) : '0;
      b_empty    = ($urandom_range(0, 31) == 0);
      result_ack = ($urandom_range(0, 2) == 0);
      rst_n      = ($urandom_range(0, 199) == 0);
      tick();
    end
    idle_inputs();
    basic_pass(1'b0, "final");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
